md_unit: RTL and testbench

Multiply/divide unit for the five-stage MIPS pipeline: the writer of the HI/LO register pair that the E-stage ALU reads for `mfhi`/`mflo`. It executes `mult`, `multu`, `div`, `divu`, `mthi` and `mtlo` issued from E. It holds the architectural HI/LO values and raises `busy` so the hazard unit can stall later HI/LO users. Multiplies take 5 cycles, divides 10; results commit atomically at the end.

---
 rtl/md_unit.sv | 132 +++++++++++++
 tb/tb_md_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// HI/LO multiply/divide unit: captures the product or quotient/remainder at issue,
// then holds busy for a fixed latency before committing to the architectural HI/LO.
//
// state | meaning
// IDLE  | counter = 0, ready to accept an MD op
// RUN   | counter > 0, result held in res_*, commits as counter goes 1 -> 0
module md_unit (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] rd1_i,
  input  logic [31:0] rd2_i,
  input  logic        cancel_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_o
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_LAT = 4'd5;
  localparam logic [3:0] DIV_LAT  = 4'd10;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic        supp_q, supp_d;

  logic        accept;
  logic        sgn;
  logic [63:0] ext_a, ext_b, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  assign busy_o = (cnt_q != 4'd0);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign accept = start_i & ~cancel_i & ~busy_o;
  assign sgn    = (op_i == OP_MULT) | (op_i == OP_DIV);

  // 64x64 product of sign/zero-extended operands; low 64 bits equal the signed product.
  assign ext_a = sgn ? {{32{rd1_i[31]}}, rd1_i} : {32'd0, rd1_i};
  assign ext_b = sgn ? {{32{rd2_i[31]}}, rd2_i} : {32'd0, rd2_i};
  assign prod  = ext_a * ext_b;

  // Divide on magnitudes so INT_MIN / -1 wraps to INT_MIN instead of overflowing.
  assign a_neg  = sgn & rd1_i[31];
  assign b_neg  = sgn & rd2_i[31];
  assign a_mag  = a_neg ? (~rd1_i + 32'd1) : rd1_i;
  assign b_mag  = b_neg ? (~rd2_i + 32'd1) : rd2_i;
  assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign quot   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem    = a_neg ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    supp_d   = supp_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op_i)
            OP_MULT, OP_MULTU: begin
              res_hi_d = prod[63:32];
              res_lo_d = prod[31:0];
              supp_d   = 1'b0;
              cnt_d    = MULT_LAT;
              state_d  = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              res_hi_d = rem;
              res_lo_d = quot;
              supp_d   = (rd2_i == 32'd0);
              cnt_d    = DIV_LAT;
              state_d  = S_RUN;
            end
            OP_MTHI: hi_d = rd1_i;
            OP_MTLO: lo_d = rd1_i;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
          if (!supp_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      supp_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      supp_q   <= supp_d;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: hand-computed HI/LO results, busy windows,
// cancel, start-while-busy and mid-operation reset.
module tb_md_unit;

  logic        clk_i;
  logic        reset_i;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] rd1_i;
  logic [31:0] rd2_i;
  logic        cancel_i;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  md_unit dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .start_i  (start_i),
    .op_i     (op_i),
    .rd1_i    (rd1_i),
    .rd2_i    (rd2_i),
    .cancel_i (cancel_i),
    .hi_o     (hi_o),
    .lo_o     (lo_o),
    .busy_o   (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Presents an op for one cycle; returns 1 time unit after the sampling edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start_i = 1'b1;
    op_i    = op;
    rd1_i   = a;
    rd2_i   = b;
    tick();
    start_i = 1'b0;
    op_i    = 3'd0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input int lat,
                        input logic [31:0] pre_hi, input logic [31:0] pre_lo,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    issue(op, a, b);
    for (int k = 0; k < lat; k++) begin
      if (k > 0) tick();
      check_eq($sformatf("%s busy E%0d", tag, k), {31'd0, busy_o}, 32'd1);
      check_eq($sformatf("%s hold hi E%0d", tag, k), hi_o, pre_hi);
      check_eq($sformatf("%s hold lo E%0d", tag, k), lo_o, pre_lo);
    end
    tick();
    check_eq({tag, " busy done"}, {31'd0, busy_o}, 32'd0);
    check_eq({tag, " hi"}, hi_o, exp_hi);
    check_eq({tag, " lo"}, lo_o, exp_lo);
  endtask

  initial begin
    reset_i  = 1'b0;
    start_i  = 1'b0;
    op_i     = 3'd0;
    rd1_i    = 32'd0;
    rd2_i    = 32'd0;
    cancel_i = 1'b0;
    tick();
    tick();
    reset_i = 1'b1;
    check_eq("reset hi", hi_o, 32'd0);
    check_eq("reset lo", lo_o, 32'd0);
    check_eq("reset busy", {31'd0, busy_o}, 32'd0);

    run_op("mult -3*5", 3'd1, 32'hFFFF_FFFD, 32'd5, 5,
           32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("multu ffffffff*2", 3'd2, 32'hFFFF_FFFF, 32'd2, 5,
           32'hFFFF_FFFF, 32'hFFFF_FFF1, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div -7/2", 3'd3, 32'hFFFF_FFF9, 32'd2, 10,
           32'h0000_0001, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu 7/2", 3'd4, 32'd7, 32'd2, 10,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1, 32'd3);
    run_op("div min/-1", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10,
           32'd1, 32'd3, 32'd0, 32'h8000_0000);

    issue(3'd5, 32'h0000_1234, 32'd0);
    check_eq("mthi hi", hi_o, 32'h0000_1234);
    check_eq("mthi lo", lo_o, 32'h8000_0000);
    check_eq("mthi busy", {31'd0, busy_o}, 32'd0);

    run_op("divu 7/0", 3'd4, 32'd7, 32'd0, 10,
           32'h0000_1234, 32'h8000_0000, 32'h0000_1234, 32'h8000_0000);

    issue(3'd6, 32'hCAFE_BABE, 32'd0);
    check_eq("mtlo lo", lo_o, 32'hCAFE_BABE);
    check_eq("mtlo hi", hi_o, 32'h0000_1234);
    check_eq("mtlo busy", {31'd0, busy_o}, 32'd0);

    cancel_i = 1'b1;
    issue(3'd1, 32'd9, 32'd9);
    cancel_i = 1'b0;
    check_eq("cancel busy", {31'd0, busy_o}, 32'd0);
    repeat (6) tick();
    check_eq("cancel busy later", {31'd0, busy_o}, 32'd0);
    check_eq("cancel hi", hi_o, 32'h0000_1234);
    check_eq("cancel lo", lo_o, 32'hCAFE_BABE);

    run_op("b2b mult 3*4", 3'd1, 32'd3, 32'd4, 5,
           32'h0000_1234, 32'hCAFE_BABE, 32'd0, 32'd12);
    run_op("b2b multu 2^16*2^16", 3'd2, 32'h0001_0000, 32'h0001_0000, 5,
           32'd0, 32'd12, 32'd1, 32'd0);

    issue(3'd3, 32'd100, 32'd7);
    tick();
    tick();
    check_eq("ignore busy before", {31'd0, busy_o}, 32'd1);
    if (busy_o) $display("protocol note: start issued while busy (expected to be ignored)");
    issue(3'd1, 32'd2, 32'd3);
    repeat (6) tick();
    check_eq("ignore busy E9", {31'd0, busy_o}, 32'd1);
    check_eq("ignore hold hi E9", hi_o, 32'd1);
    check_eq("ignore hold lo E9", lo_o, 32'd0);
    tick();
    check_eq("ignore busy E10", {31'd0, busy_o}, 32'd0);
    check_eq("ignore div hi", hi_o, 32'd2);
    check_eq("ignore div lo", lo_o, 32'd14);
    tick();
    check_eq("ignore no restart", {31'd0, busy_o}, 32'd0);
    check_eq("ignore hi stable", hi_o, 32'd2);

    issue(3'd3, 32'd100, 32'd7);
    tick();
    tick();
    reset_i = 1'b0;
    tick();
    reset_i = 1'b1;
    check_eq("midreset busy", {31'd0, busy_o}, 32'd0);
    check_eq("midreset hi", hi_o, 32'd0);
    check_eq("midreset lo", lo_o, 32'd0);
    repeat (10) tick();
    check_eq("midreset no commit busy", {31'd0, busy_o}, 32'd0);
    check_eq("midreset no commit hi", hi_o, 32'd0);
    check_eq("midreset no commit lo", lo_o, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
